// File: rtl/id_branch_hazard_unit.sv
// IF/ID pipeline register with ID-stage branch/jump resolution, load-use and
// branch-operand hazard detection, and saturating stall/flush counters.
module id_branch_hazard_unit #(
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] PC,
  input  logic [31:0] Instruction,
  input  logic [31:0] Rs1Data,
  input  logic [31:0] Rs2Data,
  input  logic        ExRegWrite,
  input  logic        ExMemRead,
  input  logic [4:0]  ExRd,
  input  logic        MemMemRead,
  input  logic [4:0]  MemRd,
  output logic        Branch,
  output logic [11:0] BranchAddr,
  output logic        PCWrite,
  output logic [11:0] IfIdPC,
  output logic [31:0] IfIdInst,
  output logic        IfIdValid,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic        IdBubble,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [11:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;
  logic [15:0] r_stallCnt;
  logic [15:0] r_flushCnt;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_isBranch;
  logic        w_isJal;
  logic        w_isJalr;
  logic        w_uses1;
  logic        w_uses2;
  logic        w_exMatch;
  logic        w_memMatch;
  logic        w_loadUse;
  logic        w_branchOp;
  logic        w_stall;
  logic        w_cond;
  logic        w_taken;
  logic        w_branch;
  logic [11:0] w_immB;
  logic [11:0] w_immJ;
  logic [11:0] w_immI;
  logic [11:0] w_target;

  assign w_opcode   = r_inst[6:0];
  assign w_funct3   = r_inst[14:12];
  assign w_isBranch = (w_opcode == OP_BRANCH);
  assign w_isJal    = (w_opcode == OP_JAL);
  assign w_isJalr   = (w_opcode == OP_JALR);
  assign w_uses1    = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || w_isJal);
  assign w_uses2    = (w_opcode == OP_R) || (w_opcode == OP_STORE) || w_isBranch;

  assign Rs1 = r_inst[19:15];
  assign Rs2 = r_inst[24:20];

  assign w_exMatch  = (ExRd != 5'd0) &&
                      ((w_uses1 && (Rs1 == ExRd)) || (w_uses2 && (Rs2 == ExRd)));
  assign w_memMatch = (MemRd != 5'd0) &&
                      ((w_uses1 && (Rs1 == MemRd)) || (w_uses2 && (Rs2 == MemRd)));

  assign w_loadUse  = ExMemRead && w_exMatch;
  assign w_branchOp = (w_isBranch || w_isJalr) &&
                      ((ExRegWrite && w_exMatch) || (MemMemRead && w_memMatch));
  assign w_stall    = r_valid && (w_loadUse || w_branchOp);

  // Immediates only need their low 12 bits since targets wrap at 4096.
  assign w_immB = {r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
  assign w_immJ = {r_inst[20], r_inst[30:21], 1'b0};
  assign w_immI = r_inst[31:20];

  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      3'b000:  w_cond = (Rs1Data == Rs2Data);
      3'b001:  w_cond = (Rs1Data != Rs2Data);
      3'b100:  w_cond = ($signed(Rs1Data) <  $signed(Rs2Data));
      3'b101:  w_cond = ($signed(Rs1Data) >= $signed(Rs2Data));
      3'b110:  w_cond = (Rs1Data <  Rs2Data);
      3'b111:  w_cond = (Rs1Data >= Rs2Data);
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_target = 12'd0;
    if (w_isJalr)
      w_target = (Rs1Data[11:0] + w_immI) & ~12'h001;
    else if (w_isJal)
      w_target = r_pc + w_immJ;
    else
      w_target = r_pc + w_immB;
  end

  assign w_taken  = w_isJal || w_isJalr || (w_isBranch && w_cond);
  assign w_branch = r_valid && !w_stall && w_taken;

  assign Branch     = w_branch;
  assign BranchAddr = w_branch ? w_target : 12'd0;
  assign PCWrite    = !w_stall;
  assign IdBubble   = w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= 12'd0;
      r_inst  <= NOP;
      r_valid <= 1'b0;
    end else if (w_stall) begin
      r_pc    <= r_pc;
      r_inst  <= r_inst;
      r_valid <= r_valid;
    end else if (w_branch) begin
      r_pc    <= 12'd0;
      r_inst  <= NOP;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= PC;
      r_inst  <= Instruction;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= 16'd0;
      r_flushCnt <= 16'd0;
    end else begin
      if (w_stall && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
      if (w_branch && (r_flushCnt != 16'hFFFF))
        r_flushCnt <= r_flushCnt + 16'd1;
    end
  end

  assign IfIdPC    = r_pc;
  assign IfIdInst  = r_inst;
  assign IfIdValid = r_valid;
  assign StallCnt  = r_stallCnt;
  assign FlushCnt  = r_flushCnt;

endmodule

// File: tb/tb_id_branch_hazard_unit.sv
// Directed testbench for id_branch_hazard_unit; expected values are hand-computed.
module tb_id_branch_hazard_unit;

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] ADDI_X1   = 32'h00100093;
  localparam logic [31:0] ADD_X3    = 32'h002081B3;
  localparam logic [31:0] BEQ_M8    = 32'hFE208CE3;
  localparam logic [31:0] BLT_P8    = 32'h0020C463;
  localparam logic [31:0] BLTU_P8   = 32'h0020E463;
  localparam logic [31:0] JALR_2    = 32'h00208067;
  localparam logic [31:0] BNE_X4_P8 = 32'h00521463;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] PC;
  logic [31:0] Instruction;
  logic [31:0] Rs1Data, Rs2Data;
  logic        ExRegWrite, ExMemRead, MemMemRead;
  logic [4:0]  ExRd, MemRd;
  logic        Branch, PCWrite, IfIdValid, IdBubble;
  logic [11:0] BranchAddr, IfIdPC;
  logic [31:0] IfIdInst;
  logic [4:0]  Rs1, Rs2;
  logic [15:0] StallCnt, FlushCnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] expStall = 16'd0;
  logic [15:0] expFlush = 16'd0;

  id_branch_hazard_unit #(.NOP(NOP)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Instruction(Instruction),
    .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExRd(ExRd),
    .MemMemRead(MemMemRead), .MemRd(MemRd),
    .Branch(Branch), .BranchAddr(BranchAddr), .PCWrite(PCWrite),
    .IfIdPC(IfIdPC), .IfIdInst(IfIdInst), .IfIdValid(IfIdValid),
    .Rs1(Rs1), .Rs2(Rs2), .IdBubble(IdBubble),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic clearHazards();
    ExRegWrite = 1'b0;
    ExMemRead  = 1'b0;
    ExRd       = 5'd0;
    MemMemRead = 1'b0;
    MemRd      = 5'd0;
  endtask

  // Drive one fetch at the falling edge and let the next rising edge latch it.
  task automatic applyStimulus(input logic [11:0] pc, input logic [31:0] inst);
    @(negedge clk);
    rst = 1'b0;
    clearHazards();
    PC = pc;
    Instruction = inst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearHazards();
    PC = 12'h000; Instruction = ADDI_X1; Rs1Data = 0; Rs2Data = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (IfIdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", IfIdValid); end
    checks++; if (IfIdInst !== NOP) begin errors++; $display("[TB] FAIL reset_inst got=%h exp=%h", IfIdInst, NOP); end
    checks++; if (IfIdPC !== 12'h000) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=000", IfIdPC); end
    checks++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%h/%h exp=0/0", StallCnt, FlushCnt); end
    checks++; if (PCWrite !== 1'b1 || Branch !== 1'b0 || IdBubble !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl got pcw=%b br=%b bub=%b exp 1/0/0", PCWrite, Branch, IdBubble); end
  endtask

  task automatic test_straight_line();
    logic [11:0] pcs [3];
    pcs[0] = 12'h000; pcs[1] = 12'h004; pcs[2] = 12'h008;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(pcs[i], ADDI_X1);
      checks++; if (IfIdPC !== pcs[i] || IfIdValid !== 1'b1) begin errors++; $display("[TB] FAIL straight_pc%0d got pc=%h v=%b exp pc=%h v=1", i, IfIdPC, IfIdValid, pcs[i]); end
      checks++; if (PCWrite !== 1'b1 || Branch !== 1'b0) begin errors++; $display("[TB] FAIL straight_ctrl%0d got pcw=%b br=%b exp 1/0", i, PCWrite, Branch); end
    end
  endtask

  task automatic test_load_use();
    applyStimulus(12'h00C, ADD_X3);
    @(negedge clk);
    PC = 12'h010; Instruction = ADDI_X1;
    ExMemRead = 1'b1; ExRd = 5'd1;
    #1;
    checks++; if (PCWrite !== 1'b0 || IdBubble !== 1'b1 || Branch !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_ctrl got pcw=%b bub=%b br=%b exp 0/1/0", PCWrite, IdBubble, Branch); end
    @(posedge clk); #1;
    expStall = expStall + 1;
    checks++; if (IfIdInst !== ADD_X3 || IfIdPC !== 12'h00C) begin errors++; $display("[TB] FAIL loaduse_hold got inst=%h pc=%h exp %h/00C", IfIdInst, IfIdPC, ADD_X3); end
    checks++; if (StallCnt !== expStall) begin errors++; $display("[TB] FAIL loaduse_cnt got=%0d exp=%0d", StallCnt, expStall); end
    @(negedge clk);
    ExRd = 5'd0;
    #1;
    checks++; if (PCWrite !== 1'b1 || IdBubble !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_x0 got pcw=%b bub=%b exp 1/0", PCWrite, IdBubble); end
    @(posedge clk); #1;
    checks++; if (IfIdPC !== 12'h010 || StallCnt !== expStall) begin errors++; $display("[TB] FAIL loaduse_x0_adv got pc=%h cnt=%0d exp 010/%0d", IfIdPC, StallCnt, expStall); end
  endtask

  task automatic test_beq();
    applyStimulus(12'h010, BEQ_M8);
    @(negedge clk);
    PC = 12'h014; Instruction = ADDI_X1; Rs1Data = 32'd5; Rs2Data = 32'd5;
    #1;
    checks++; if (Branch !== 1'b1 || BranchAddr !== 12'h008 || PCWrite !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken got br=%b addr=%h pcw=%b exp 1/008/1", Branch, BranchAddr, PCWrite); end
    @(posedge clk); #1;
    expFlush = expFlush + 1;
    checks++; if (IfIdInst !== NOP || IfIdValid !== 1'b0 || IfIdPC !== 12'h000) begin errors++; $display("[TB] FAIL beq_flush got inst=%h v=%b pc=%h exp %h/0/000", IfIdInst, IfIdValid, IfIdPC, NOP); end
    checks++; if (FlushCnt !== expFlush) begin errors++; $display("[TB] FAIL beq_flushcnt got=%0d exp=%0d", FlushCnt, expFlush); end
    checks++; if (Branch !== 1'b0 || IdBubble !== 1'b0) begin errors++; $display("[TB] FAIL flushed_slot got br=%b bub=%b exp 0/0", Branch, IdBubble); end
    applyStimulus(12'h010, BEQ_M8);
    @(negedge clk);
    Rs2Data = 32'd6;
    #1;
    checks++; if (Branch !== 1'b0 || BranchAddr !== 12'h000 || PCWrite !== 1'b1) begin errors++; $display("[TB] FAIL beq_not_taken got br=%b addr=%h pcw=%b exp 0/000/1", Branch, BranchAddr, PCWrite); end
  endtask

  task automatic test_blt_bltu();
    applyStimulus(12'h100, BLT_P8);
    @(negedge clk);
    Rs1Data = 32'hFFFFFFFF; Rs2Data = 32'd1;
    #1;
    checks++; if (Branch !== 1'b1 || BranchAddr !== 12'h108) begin errors++; $display("[TB] FAIL blt_taken got br=%b addr=%h exp 1/108", Branch, BranchAddr); end
    @(posedge clk); #1;
    expFlush = expFlush + 1;
    applyStimulus(12'h200, BLTU_P8);
    @(negedge clk);
    Rs1Data = 32'hFFFFFFFF; Rs2Data = 32'd1;
    #1;
    checks++; if (Branch !== 1'b0) begin errors++; $display("[TB] FAIL bltu_not_taken got br=%b exp 0", Branch); end
  endtask

  task automatic test_jalr_wrap();
    applyStimulus(12'h300, JALR_2);
    @(negedge clk);
    Rs1Data = 32'h00000FFF;
    #1;
    checks++; if (Branch !== 1'b1 || BranchAddr !== 12'h000) begin errors++; $display("[TB] FAIL jalr_wrap got br=%b addr=%h exp 1/000", Branch, BranchAddr); end
    @(posedge clk); #1;
    expFlush = expFlush + 1;
    checks++; if (FlushCnt !== expFlush || IfIdValid !== 1'b0) begin errors++; $display("[TB] FAIL jalr_flush got cnt=%0d v=%b exp %0d/0", FlushCnt, IfIdValid, expFlush); end
  endtask

  task automatic test_branch_after_load();
    applyStimulus(12'h040, BNE_X4_P8);
    checks++; if (Rs1 !== 5'd4 || Rs2 !== 5'd5) begin errors++; $display("[TB] FAIL bne_regs got rs1=%0d rs2=%0d exp 4/5", Rs1, Rs2); end
    @(negedge clk);
    Rs1Data = 32'd1; Rs2Data = 32'd2;
    ExMemRead = 1'b1; ExRegWrite = 1'b1; ExRd = 5'd4;
    #1;
    checks++; if (PCWrite !== 1'b0 || Branch !== 1'b0 || IdBubble !== 1'b1) begin errors++; $display("[TB] FAIL bne_stall_ex got pcw=%b br=%b bub=%b exp 0/0/1", PCWrite, Branch, IdBubble); end
    @(posedge clk); #1;
    expStall = expStall + 1;
    @(negedge clk);
    ExMemRead = 1'b0; ExRegWrite = 1'b0; ExRd = 5'd0;
    MemMemRead = 1'b1; MemRd = 5'd4;
    #1;
    checks++; if (PCWrite !== 1'b0 || Branch !== 1'b0 || IdBubble !== 1'b1) begin errors++; $display("[TB] FAIL bne_stall_mem got pcw=%b br=%b bub=%b exp 0/0/1", PCWrite, Branch, IdBubble); end
    @(posedge clk); #1;
    expStall = expStall + 1;
    checks++; if (IfIdInst !== BNE_X4_P8 || StallCnt !== expStall) begin errors++; $display("[TB] FAIL bne_hold got inst=%h cnt=%0d exp %h/%0d", IfIdInst, StallCnt, BNE_X4_P8, expStall); end
    @(negedge clk);
    MemMemRead = 1'b0; MemRd = 5'd0;
    #1;
    checks++; if (Branch !== 1'b1 || BranchAddr !== 12'h048 || PCWrite !== 1'b1) begin errors++; $display("[TB] FAIL bne_resolve got br=%b addr=%h pcw=%b exp 1/048/1", Branch, BranchAddr, PCWrite); end
    @(posedge clk); #1;
    expFlush = expFlush + 1;
    // ALU producer in EX stalls a branch once; an ALU result in MEM does not.
    applyStimulus(12'h050, BNE_X4_P8);
    @(negedge clk);
    ExRegWrite = 1'b1; ExRd = 5'd5;
    #1;
    checks++; if (IdBubble !== 1'b1 || Branch !== 1'b0) begin errors++; $display("[TB] FAIL bne_alu_ex got bub=%b br=%b exp 1/0", IdBubble, Branch); end
    @(posedge clk); #1;
    expStall = expStall + 1;
    @(negedge clk);
    ExRegWrite = 1'b0; ExRd = 5'd0; MemRd = 5'd5;
    #1;
    checks++; if (IdBubble !== 1'b0 || Branch !== 1'b1 || BranchAddr !== 12'h058) begin errors++; $display("[TB] FAIL bne_alu_mem got bub=%b br=%b addr=%h exp 0/1/058", IdBubble, Branch, BranchAddr); end
    @(posedge clk); #1;
    expFlush = expFlush + 1;
    checks++; if (StallCnt !== expStall || FlushCnt !== expFlush) begin errors++; $display("[TB] FAIL cnt_totals got %0d/%0d exp %0d/%0d", StallCnt, FlushCnt, expStall, expFlush); end
  endtask

  task automatic test_saturation();
    applyStimulus(12'h060, ADD_X3);
    @(negedge clk);
    ExMemRead = 1'b1; ExRd = 5'd2;
    repeat (65540) @(posedge clk);
    #1;
    checks++; if (StallCnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL stall_saturate got=%h exp=FFFF", StallCnt); end
    @(posedge clk); #1;
    checks++; if (StallCnt !== 16'hFFFF || IfIdInst !== ADD_X3) begin errors++; $display("[TB] FAIL stall_hold_sat got cnt=%h inst=%h exp FFFF/%h", StallCnt, IfIdInst, ADD_X3); end
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (IdBubble !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_stall got bub=%b exp 1", IdBubble); end
    @(posedge clk); #1;
    checks++; if (IfIdValid !== 1'b0 || IfIdInst !== NOP || StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_over_stall got v=%b inst=%h cnt=%h/%h exp 0/%h/0/0", IfIdValid, IfIdInst, StallCnt, FlushCnt, NOP); end
    checks++; if (PCWrite !== 1'b1 || IdBubble !== 1'b0) begin errors++; $display("[TB] FAIL reset_over_ctrl got pcw=%b bub=%b exp 1/0", PCWrite, IdBubble); end
    applyStimulus(12'h070, JALR_2);
    @(negedge clk);
    rst = 1'b1; Rs1Data = 32'h100;
    #1;
    @(posedge clk); #1;
    checks++; if (FlushCnt !== 16'd0 || IfIdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_over_branch got cnt=%0d v=%b exp 0/0", FlushCnt, IfIdValid); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_load_use();
    test_beq();
    test_blt_bltu();
    test_jalr_wrap();
    test_branch_after_load();
    test_saturation();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
